clk_count_mod: RTL and testbench
================================

# clk_count_mod

Parametrised modulo counter for the digital-clock datapath: the generalised successor of the fixed minute counter. It covers the seconds, minutes and hours stages with one module. Beyond a plain up-count it adds down-counting, a wrap or saturate mode, a range-checked synchronous load for time setting, a borrow output, and registered BCD digits for the display driver. Instances chain through `carry_out`/`borrow_out` into the next stage's `inc`/`dec`.

## Interface
- `WIDTH`, default 8: width of `value` and `load_val`; must satisfy 2^WIDTH >= `MODULO`.
- `MODULO`, default 60: count range is 0..`MODULO`-1; legal range 2..100, because the BCD outputs are limited to two digits.
- `CLK`  in  1: clock; all state changes on the rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `clr`  in  1: synchronous clear to 0.
- `load`  in  1: synchronous load strobe.
- `load_val`  in  `WIDTH`: value to load.
- `inc`  in  1: count-up enable, one step per cycle while high.
- `dec`  in  1: count-down enable, one step per cycle while high.
- `wrap_en`  in  1: 1 selects wrap at the limits; 0 selects saturate at the limits.
- `value`  out  `WIDTH`: current count, registered.
- `bcd_tens`  out  4: tens digit of `value`, registered.
- `bcd_units`  out  4: units digit of `value`, registered.
- `carry_out`  out  1: combinational; high while the up-wrap condition holds.
- `borrow_out`  out  1: combinational; high while the down-wrap condition holds.
- `load_err`  out  1: registered one-cycle pulse flagging a rejected load.

## Operation
- Reset values: `value`=0, `bcd_tens`=0, `bcd_units`=0, `load_err`=0; `carry_out` and `borrow_out` are 0 whenever `rst_n`=0.
- Per-edge priority, highest first: `clr`, `load`, then `inc`/`dec`.
- `clr`=1: `value` goes to 0; `load`, `inc` and `dec` are ignored that cycle.
- `load`=1 with `load_val` < `MODULO`: `value` takes `load_val`; `inc` and `dec` are ignored.
- `load`=1 with `load_val` >= `MODULO`: `value` holds and `load_err` pulses for one cycle; `inc` and `dec` are still ignored.
- `inc`=1 and `dec`=1 in the same cycle: `value` holds, and no carry or borrow is produced.
- `inc` only:
  - `value` < `MODULO`-1: increment by 1.
  - `value` = `MODULO`-1 and `wrap_en`=1: next value is 0.
  - `value` = `MODULO`-1 and `wrap_en`=0: `value` holds.
- `dec` only:
  - `value` > 0: decrement by 1.
  - `value` = 0 and `wrap_en`=1: next value is `MODULO`-1.
  - `value` = 0 and `wrap_en`=0: `value` holds.
- `carry_out` = `inc` & ~`dec` & `wrap_en` & (`value`==`MODULO`-1) & ~`clr` & ~`load`.
- `borrow_out` = `dec` & ~`inc` & `wrap_en` & (`value`==0) & ~`clr` & ~`load`.
- A saturating hold never asserts `carry_out` or `borrow_out`.
- BCD digits: held in their own tens/units registers and updated in lockstep with `value`.
  - Increment and decrement adjust the digit pair directly, with units rolling 9↔0.
  - Load and clear compute the digits from the new value.
  - No combinational divider on the output path.
  - Invariant: `bcd_tens`*10 + `bcd_units` == `value` on every cycle.
- Arithmetic is unsigned at `WIDTH` bits; no intermediate result may exceed `MODULO`-1.

## Timing
- `value`, `bcd_tens` and `bcd_units` change on the edge where the command is sampled; latency is 1 cycle.
- `carry_out` and `borrow_out` are valid in the same cycle as the qualifying `inc`/`dec`. This lets the next stage step on that same edge, so a chain ripples with 0 extra cycles.
- `load_err` is high for the one cycle after the rejected `load` edge.
- `rst_n` asserted mid-count clears all registers immediately, independent of `CLK`.
- Release of `rst_n` is synchronised externally; the first edge after release obeys normal priority.

## Test plan
- Reset, then `inc` held for 60 cycles with `MODULO`=60 and `wrap_en`=1:
  - `value` steps 0..59 and returns to 0.
  - `carry_out` is high exactly once, in the cycle where `value`=59.
  - BCD reads 5/9 and then 0/0.
- `dec` from 0 with `wrap_en`=1 → `value`=59, `borrow_out` is high in that cycle, BCD reads 5/9. With `wrap_en`=0 → `value` stays 0 and `borrow_out`=0.
- `load`=1 with `load_val`=45 → `value`=45, BCD 4/5, `load_err`=0. Then `load_val`=60 → `value` stays 45 and `load_err` pulses for 1 cycle.
- `clr`, `load` and `inc` asserted together at `value`=30 → `value`=0. Then `inc` and `dec` together → `value` holds at 0, and `carry_out`/`borrow_out` stay 0.
- `MODULO`=24 instance fed from a `MODULO`=60 instance's `carry_out`, starting at 23:59, one `inc` → both instances read 0 on the same edge, and the hour stage's `carry_out` pulses.
- `rst_n` asserted asynchronously mid-cycle at `value`=37 → `value`, BCD and `load_err` go to 0 before the next edge.

Source files
------------

// File: rtl/clk_count_mod_if.sv
// Command/status bundle for one clk_count_mod stage.
//   master: drives clr, load, load_val, inc, dec, wrap_en; observes the count,
//           BCD digits, carry_out, borrow_out and load_err.
//   slave : the counter stage itself (opposite directions).
interface clk_count_mod_if #(
   parameter int unsigned WIDTH = 8
);
   logic             clr;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic             inc;
   logic             dec;
   logic             wrap_en;
   logic [WIDTH-1:0] value;
   logic [3:0]       bcd_tens;
   logic [3:0]       bcd_units;
   logic             carry_out;
   logic             borrow_out;
   logic             load_err;

   modport master (
      output clr, load, load_val, inc, dec, wrap_en,
      input  value, bcd_tens, bcd_units, carry_out, borrow_out, load_err
   );

   modport slave (
      input  clr, load, load_val, inc, dec, wrap_en,
      output value, bcd_tens, bcd_units, carry_out, borrow_out, load_err
   );
endinterface

// File: rtl/clk_count_mod.sv
// Parametrised modulo counter stage for the digital-clock datapath (seconds,
// minutes, hours). Counts 0..MODULO-1 up or down, wraps or saturates at the
// limits, accepts a range-checked synchronous load, and keeps registered BCD
// digits that track the count without a divider on the output path.
// Ports:
//   CLK   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of clk_count_mod_if (commands in; value, BCD digits,
//           combinational carry_out/borrow_out and registered load_err out)
module clk_count_mod #(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned MODULO = 60
) (
   input logic            CLK,
   input logic            rst_n,
   clk_count_mod_if.slave bus
);

   localparam logic [WIDTH-1:0] MaxVal   = WIDTH'(MODULO - 1);
   localparam logic [3:0]       MaxTens  = 4'((MODULO - 1) / 10);
   localparam logic [3:0]       MaxUnits = 4'((MODULO - 1) % 10);

   logic [WIDTH-1:0] value_q, value_d;
   logic [3:0]       tens_q, tens_d;
   logic [3:0]       units_q, units_d;
   logic             load_err_q, load_err_d;

   logic        at_max, at_zero, up_only, dn_only, load_ok;
   int unsigned lv;

   assign at_max  = (value_q == MaxVal);
   assign at_zero = (value_q == '0);
   assign up_only = bus.inc & ~bus.dec;
   assign dn_only = bus.dec & ~bus.inc;
   assign load_ok = (bus.load_val <= MaxVal);

   always_comb begin
      value_d    = value_q;
      tens_d     = tens_q;
      units_d    = units_q;
      load_err_d = 1'b0;
      lv         = 0;
      if (bus.clr) begin
         value_d = '0;
         tens_d  = 4'd0;
         units_d = 4'd0;
      end else if (bus.load) begin
         if (load_ok) begin
            // Digit split lives only on the load path; load_val < MODULO <= 100.
            value_d = bus.load_val;
            lv      = 32'(bus.load_val);
            tens_d  = 4'(lv / 10);
            units_d = 4'(lv % 10);
         end else begin
            load_err_d = 1'b1;
         end
      end else if (up_only) begin
         if (!at_max) begin
            value_d = value_q + WIDTH'(1);
            if (units_q == 4'd9) begin
               units_d = 4'd0;
               tens_d  = tens_q + 4'd1;
            end else begin
               units_d = units_q + 4'd1;
            end
         end else if (bus.wrap_en) begin
            value_d = '0;
            tens_d  = 4'd0;
            units_d = 4'd0;
         end
      end else if (dn_only) begin
         if (!at_zero) begin
            value_d = value_q - WIDTH'(1);
            if (units_q == 4'd0) begin
               units_d = 4'd9;
               tens_d  = tens_q - 4'd1;
            end else begin
               units_d = units_q - 4'd1;
            end
         end else if (bus.wrap_en) begin
            value_d = MaxVal;
            tens_d  = MaxTens;
            units_d = MaxUnits;
         end
      end
   end

   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         value_q    <= '0;
         tens_q     <= 4'd0;
         units_q    <= 4'd0;
         load_err_q <= 1'b0;
      end else begin
         value_q    <= value_d;
         tens_q     <= tens_d;
         units_q    <= units_d;
         load_err_q <= load_err_d;
      end
   end

   assign bus.value     = value_q;
   assign bus.bcd_tens  = tens_q;
   assign bus.bcd_units = units_q;
   assign bus.load_err  = load_err_q;

   // Same-cycle wrap flags so the next stage steps on this very edge.
   assign bus.carry_out  = rst_n & up_only & bus.wrap_en & at_max & ~bus.clr & ~bus.load;
   assign bus.borrow_out = rst_n & dn_only & bus.wrap_en & at_zero & ~bus.clr & ~bus.load;

endmodule

// File: tb/tb_clk_count_mod.sv
// Bench for clk_count_mod: a MODULO=60 minute stage whose carry_out feeds a
// MODULO=24 hour stage. Expected results are queued when stimulus is driven
// and popped/compared one edge later.
module tb_clk_count_mod;

   localparam int Mod = 60;

   logic CLK = 1'b0;
   logic rst_n;

   int errors     = 0;
   int checks     = 0;
   int carry_seen = 0;
   int mval       = 0;
   bit h_carry_pre;

   typedef struct {
      int v;
      bit err;
   } exp_t;

   exp_t sb[$];

   always #5 CLK = ~CLK;

   clk_count_mod_if #(.WIDTH(8)) m_if ();
   clk_count_mod_if #(.WIDTH(8)) h_if ();

   assign h_if.inc = m_if.carry_out;

   clk_count_mod #(.WIDTH(8), .MODULO(60)) u_min (
      .CLK   (CLK),
      .rst_n (rst_n),
      .bus   (m_if)
   );

   clk_count_mod #(.WIDTH(8), .MODULO(24)) u_hour (
      .CLK   (CLK),
      .rst_n (rst_n),
      .bus   (h_if)
   );

   // One command cycle on the minute stage: drive, check comb flags, queue the
   // model result, then compare after the edge.
   task automatic drive_cycle(input bit c, input bit l, input int lv, input bit i,
                              input bit d, input bit w);
      exp_t e;
      bit   ec, eb, nerr;
      int   nv;
      @(negedge CLK);
      m_if.clr      = c;
      m_if.load     = l;
      m_if.load_val = 8'(lv);
      m_if.inc      = i;
      m_if.dec      = d;
      m_if.wrap_en  = w;
      #1;
      ec = i && !d && w && (mval == Mod - 1) && !c && !l;
      eb = d && !i && w && (mval == 0) && !c && !l;
      checks++;
      if (m_if.carry_out !== ec) begin
         errors++;
         $display("FAIL carry_out: got %b expected %b at value %0d", m_if.carry_out, ec, mval);
      end
      checks++;
      if (m_if.borrow_out !== eb) begin
         errors++;
         $display("FAIL borrow_out: got %b expected %b at value %0d", m_if.borrow_out, eb, mval);
      end
      if (m_if.carry_out === 1'b1) carry_seen++;
      h_carry_pre = h_if.carry_out;
      nv   = mval;
      nerr = 1'b0;
      if (c) nv = 0;
      else if (l) begin
         if (lv < Mod) nv = lv;
         else nerr = 1'b1;
      end else if (i && !d) begin
         if (mval < Mod - 1) nv = mval + 1;
         else if (w) nv = 0;
      end else if (d && !i) begin
         if (mval > 0) nv = mval - 1;
         else if (w) nv = Mod - 1;
      end
      mval  = nv;
      e.v   = nv;
      e.err = nerr;
      sb.push_back(e);
      @(posedge CLK);
      #1;
      e = sb.pop_front();
      checks++;
      if (m_if.value !== 8'(e.v)) begin
         errors++;
         $display("FAIL value: got %0d expected %0d", m_if.value, e.v);
      end
      checks++;
      if (m_if.bcd_tens !== 4'(e.v / 10)) begin
         errors++;
         $display("FAIL bcd_tens: got %0d expected %0d", m_if.bcd_tens, e.v / 10);
      end
      checks++;
      if (m_if.bcd_units !== 4'(e.v % 10)) begin
         errors++;
         $display("FAIL bcd_units: got %0d expected %0d", m_if.bcd_units, e.v % 10);
      end
      checks++;
      if (m_if.load_err !== e.err) begin
         errors++;
         $display("FAIL load_err: got %b expected %b", m_if.load_err, e.err);
      end
   endtask

   task automatic test_reset();
      rst_n         = 1'b0;
      m_if.clr      = 1'b0;
      m_if.load     = 1'b0;
      m_if.load_val = 8'd0;
      m_if.inc      = 1'b0;
      m_if.dec      = 1'b1;
      m_if.wrap_en  = 1'b1;
      h_if.clr      = 1'b0;
      h_if.load     = 1'b0;
      h_if.load_val = 8'd0;
      h_if.dec      = 1'b0;
      h_if.wrap_en  = 1'b1;
      #12;
      checks++;
      if (m_if.value !== 8'd0 || m_if.bcd_tens !== 4'd0 || m_if.bcd_units !== 4'd0) begin
         errors++;
         $display("FAIL reset_value: got %0d (%0d/%0d) expected 0 (0/0)", m_if.value,
                  m_if.bcd_tens, m_if.bcd_units);
      end
      checks++;
      if (m_if.load_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_load_err: got %b expected 0", m_if.load_err);
      end
      checks++;
      if (m_if.borrow_out !== 1'b0 || m_if.carry_out !== 1'b0) begin
         errors++;
         $display("FAIL reset_flags: got carry %b borrow %b expected 0 0", m_if.carry_out,
                  m_if.borrow_out);
      end
      @(negedge CLK);
      m_if.dec = 1'b0;
      rst_n    = 1'b1;
      mval     = 0;
   endtask

   task automatic test_inc_wrap();
      carry_seen = 0;
      for (int k = 0; k < 60; k++) drive_cycle(1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b1);
      checks++;
      if (carry_seen != 1) begin
         errors++;
         $display("FAIL carry_count: got %0d expected 1", carry_seen);
      end
   endtask

   task automatic test_dec();
      drive_cycle(1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b1);  // 0 -> 59 with borrow
      drive_cycle(1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b1);  // 59 -> 58
      drive_cycle(1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b1);  // clear
      drive_cycle(1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0);  // saturate at 0
   endtask

   task automatic test_load();
      drive_cycle(1'b0, 1'b1, 45, 1'b0, 1'b0, 1'b1);
      drive_cycle(1'b0, 1'b1, 60, 1'b1, 1'b0, 1'b1);  // rejected, inc ignored
      drive_cycle(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1);   // load_err drops
      drive_cycle(1'b0, 1'b1, 10, 1'b0, 1'b0, 1'b1);
      drive_cycle(1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b1);   // units borrow 10 -> 09
      drive_cycle(1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b1);   // units carry 09 -> 10
   endtask

   task automatic test_priority();
      drive_cycle(1'b0, 1'b1, 30, 1'b0, 1'b0, 1'b1);
      drive_cycle(1'b1, 1'b1, 12, 1'b1, 1'b0, 1'b1);  // clr wins
      drive_cycle(1'b0, 1'b0, 0, 1'b1, 1'b1, 1'b1);   // inc+dec hold, no borrow
      drive_cycle(1'b0, 1'b1, 59, 1'b0, 1'b0, 1'b0);
      drive_cycle(1'b0, 1'b0, 0, 1'b1, 1'b1, 1'b1);   // inc+dec at max, no carry
      drive_cycle(1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0);   // saturate at 59
      drive_cycle(1'b0, 1'b1, 59, 1'b1, 1'b0, 1'b1);  // load masks carry
   endtask

   task automatic test_chain();
      h_if.load     = 1'b1;
      h_if.load_val = 8'd23;
      drive_cycle(1'b0, 1'b1, 59, 1'b0, 1'b0, 1'b1);
      h_if.load = 1'b0;
      checks++;
      if (h_if.value !== 8'd23 || h_if.bcd_tens !== 4'd2 || h_if.bcd_units !== 4'd3) begin
         errors++;
         $display("FAIL hour_load: got %0d (%0d/%0d) expected 23 (2/3)", h_if.value,
                  h_if.bcd_tens, h_if.bcd_units);
      end
      drive_cycle(1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b1);
      checks++;
      if (h_carry_pre !== 1'b1) begin
         errors++;
         $display("FAIL hour_carry: got %b expected 1", h_carry_pre);
      end
      checks++;
      if (h_if.value !== 8'd0 || h_if.bcd_tens !== 4'd0 || h_if.bcd_units !== 4'd0) begin
         errors++;
         $display("FAIL hour_wrap: got %0d (%0d/%0d) expected 0 (0/0)", h_if.value,
                  h_if.bcd_tens, h_if.bcd_units);
      end
   endtask

   task automatic test_async_reset();
      drive_cycle(1'b0, 1'b1, 37, 1'b0, 1'b0, 1'b1);
      drive_cycle(1'b0, 1'b1, 99, 1'b0, 1'b0, 1'b1);  // leaves load_err high at 37
      #2;
      rst_n = 1'b0;
      #1;
      mval = 0;
      checks++;
      if (m_if.value !== 8'd0 || m_if.bcd_tens !== 4'd0 || m_if.bcd_units !== 4'd0) begin
         errors++;
         $display("FAIL async_reset_value: got %0d (%0d/%0d) expected 0 (0/0)", m_if.value,
                  m_if.bcd_tens, m_if.bcd_units);
      end
      checks++;
      if (m_if.load_err !== 1'b0) begin
         errors++;
         $display("FAIL async_reset_load_err: got %b expected 0", m_if.load_err);
      end
      @(negedge CLK);
      rst_n = 1'b1;
      drive_cycle(1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b1);   // first edge after release
   endtask

   initial begin
      test_reset();
      test_inc_wrap();
      test_dec();
      test_load();
      test_priority();
      test_chain();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
